// File: rtl/tile_wr_sched_if.sv
// Bundle between the cursor/trace logic and the tile RAM write scheduler.
// The master is the trace source; the slave is tile_wr_sched driving port A.
interface tile_wr_sched_if;
  logic        trace_req;
  logic [11:0] trace_addr;
  logic [6:0]  trace_din;
  logic        clear_start;
  logic        video_on;
  logic        we;
  logic [11:0] addr_w;
  logic [6:0]  din;
  logic        trace_ack;
  logic        busy;
  logic        clear_done;

  modport master (
    output trace_req, trace_addr, trace_din, clear_start, video_on,
    input  we, addr_w, din, trace_ack, busy, clear_done
  );

  modport slave (
    input  trace_req, trace_addr, trace_din, clear_start, video_on,
    output we, addr_w, din, trace_ack, busy, clear_done
  );
endinterface

// File: rtl/tile_wr_sched.sv
// Tile RAM write-port scheduler: cursor trace writes vs. full-screen clear sweep.
// Optional macro TILE_CLR_VBLANK_EN restricts sweep writes to video blanking.
module tile_wr_sched #(
  parameter int         MAX_X      = 80,
  parameter int         MAX_Y      = 30,
  parameter logic [6:0] BLANK_CHAR = 7'h00
) (
  input  logic            clk_100MHz,
  input  logic            reset_n,
  tile_wr_sched_if.slave  bus
);
  localparam logic [6:0] COL_LAST = 7'(MAX_X - 1);
  localparam logic [4:0] ROW_LAST = 5'(MAX_Y - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        hold_valid_q, hold_valid_d;
  logic [11:0] hold_addr_q, hold_addr_d;
  logic [6:0]  hold_din_q, hold_din_d;
  logic        we_q, we_d;
  logic [11:0] addr_w_q, addr_w_d;
  logic [6:0]  din_q, din_d;
  logic        trace_ack_q, trace_ack_d;
  logic        busy_q, busy_d;
  logic        clear_done_q, clear_done_d;

  logic        req_ok;
  logic        clr_en;
  logic        sweep;
  logic [6:0]  sw_col;
  logic [4:0]  sw_row;

  assign req_ok = bus.trace_req
                  && (int'(bus.trace_addr[6:0])  < MAX_X)
                  && (int'(bus.trace_addr[11:7]) < MAX_Y);

`ifdef TILE_CLR_VBLANK_EN
  assign clr_en = ~bus.video_on;
`else
  logic unused_video_on;
  assign unused_video_on = bus.video_on;
  assign clr_en = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_din_d   = hold_din_q;
    we_d         = 1'b0;
    addr_w_d     = addr_w_q;
    din_d        = din_q;
    trace_ack_d  = 1'b0;
    busy_d       = 1'b0;
    clear_done_d = 1'b0;
    sweep        = 1'b0;
    sw_col       = col_q;
    sw_row       = row_q;

    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          // The first blank write is issued from this cycle, so the sweep starts at 0,0 now.
          sweep        = 1'b1;
          sw_col       = 7'd0;
          sw_row       = 5'd0;
          state_d      = CLEAR;
          hold_valid_d = 1'b0;
          if (req_ok) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = bus.trace_addr;
            hold_din_d   = bus.trace_din;
          end
        end else if (hold_valid_q) begin
          we_d         = 1'b1;
          addr_w_d     = hold_addr_q;
          din_d        = hold_din_q;
          trace_ack_d  = 1'b1;
          hold_valid_d = req_ok;
          if (req_ok) begin
            hold_addr_d = bus.trace_addr;
            hold_din_d  = bus.trace_din;
          end
        end else if (req_ok) begin
          we_d        = 1'b1;
          addr_w_d    = bus.trace_addr;
          din_d       = bus.trace_din;
          trace_ack_d = 1'b1;
        end
      end

      CLEAR: begin
        sweep = 1'b1;
        if (req_ok) begin
          hold_valid_d = 1'b1;
          hold_addr_d  = bus.trace_addr;
          hold_din_d   = bus.trace_din;
        end
      end

      FLUSH: begin
        busy_d       = 1'b1;
        state_d      = IDLE;
        hold_valid_d = 1'b0;
        if (hold_valid_q) begin
          we_d        = 1'b1;
          addr_w_d    = hold_addr_q;
          din_d       = hold_din_q;
          trace_ack_d = 1'b1;
        end
        if (req_ok) begin
          hold_valid_d = 1'b1;
          hold_addr_d  = bus.trace_addr;
          hold_din_d   = bus.trace_din;
        end
      end

      default: state_d = IDLE;
    endcase

    // Sweep step: stalled cycles keep the position so no tile is skipped.
    if (sweep) begin
      busy_d = 1'b1;
      col_d  = sw_col;
      row_d  = sw_row;
      if (clr_en) begin
        we_d     = 1'b1;
        addr_w_d = {sw_row, sw_col};
        din_d    = BLANK_CHAR;
        if ((sw_col == COL_LAST) && (sw_row == ROW_LAST)) begin
          clear_done_d = 1'b1;
          state_d      = FLUSH;
          col_d        = 7'd0;
          row_d        = 5'd0;
        end else if (sw_col == COL_LAST) begin
          col_d = 7'd0;
          row_d = sw_row + 5'd1;
        end else begin
          col_d = sw_col + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= 7'd0;
      row_q        <= 5'd0;
      hold_valid_q <= 1'b0;
      we_q         <= 1'b0;
      addr_w_q     <= 12'd0;
      din_q        <= 7'd0;
      trace_ack_q  <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_valid_q <= hold_valid_d;
      we_q         <= we_d;
      addr_w_q     <= addr_w_d;
      din_q        <= din_d;
      trace_ack_q  <= trace_ack_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Hold payload is only meaningful while hold_valid_q is set.
  always_ff @(posedge clk_100MHz) begin
    hold_addr_q <= hold_addr_d;
    hold_din_q  <= hold_din_d;
  end

  assign bus.we         = we_q;
  assign bus.addr_w     = addr_w_q;
  assign bus.din        = din_q;
  assign bus.trace_ack  = trace_ack_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = clear_done_q;
endmodule

// File: tb/tb_tile_wr_sched.sv
// Directed bench for tile_wr_sched: every RAM write is matched against a queue
// of expected {addr, din, ack, done} entries pushed when the stimulus is driven.
module tb_tile_wr_sched;
  logic clk = 1'b0;
  logic reset_n;

  tile_wr_sched_if bus();

  tile_wr_sched #(
    .MAX_X      (80),
    .MAX_Y      (30),
    .BLANK_CHAR (7'h00)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [20:0] exp_q[$];
  bit          mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] ent(input logic [11:0] a, input logic [6:0] d,
                                      input logic ack, input logic done);
    return {a, d, ack, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [6:0] d);
    bus.trace_req  = 1'b1;
    bus.trace_addr = a;
    bus.trace_din  = d;
  endtask

  // Expected sweep: row-major over the visible 80x30 tiles, done only on tile 2399.
  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ent({5'(i / 80), 7'(i % 80)}, 7'h00, 1'b0, (i == 2399)));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'(bus.we), 32'd0);
        end else begin
          chk("write", 32'({bus.addr_w, bus.din, bus.trace_ack, bus.clear_done}),
              32'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_we_ack_done", 32'({bus.we, bus.trace_ack, bus.clear_done}), 32'd0);
      end
    end
  end

  initial begin
    int busy_cnt;

    reset_n         = 1'b0;
    bus.clear_start = 1'b0;
    bus.video_on    = 1'b0;
    drive(12'h285, 7'h41);
    repeat (3) step();
    @(negedge clk);
    chk("rst_we",         32'(bus.we),         32'd0);
    chk("rst_addr_w",     32'(bus.addr_w),     32'd0);
    chk("rst_din",        32'(bus.din),        32'd0);
    chk("rst_trace_ack",  32'(bus.trace_ack),  32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_clear_done", 32'(bus.clear_done), 32'd0);
    mon_en = 1'b1;

    // Release with trace_req still high: first ack one cycle later.
    reset_n = 1'b1;
    exp_q.push_back(ent(12'h285, 7'h41, 1'b1, 1'b0));
    step();
    bus.trace_req = 1'b0;
    step();

    // Back-to-back direct writes, including the last visible tile.
    drive(12'h3A7, 7'h2A); exp_q.push_back(ent(12'h3A7, 7'h2A, 1'b1, 1'b0)); step();
    drive(12'hECF, 7'h7F); exp_q.push_back(ent(12'hECF, 7'h7F, 1'b1, 1'b0)); step();
    // Out-of-range requests are dropped.
    drive(12'h050, 7'h55); step();
    drive(12'hF00, 7'h66); step();
    drive(12'h07F, 7'h01); step();
    drive(12'hF4F, 7'h02); step();
    bus.trace_req = 1'b0;
    step(); step();
    chk("drain_direct", 32'(exp_q.size()), 32'd0);

    // Full sweep; video_on must be ignored in the default build.
    bus.clear_start = 1'b1;
    push_sweep(2400);
    step();
    bus.clear_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 2410; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
`ifndef TILE_CLR_VBLANK_EN
      bus.video_on = 1'($urandom_range(0, 1));
`endif
      step();
    end
    bus.video_on = 1'b0;
    chk("busy_cycles", 32'(busy_cnt), 32'd2401);
    chk("drain_sweep1", 32'(exp_q.size()), 32'd0);

    // Trace requests during a sweep: last in-range request wins, flushed after done.
    bus.clear_start = 1'b1;
    push_sweep(2400);
    exp_q.push_back(ent(12'h202, 7'h22, 1'b1, 1'b0));
    step();
    bus.clear_start = 1'b0;
    repeat (100) step();
    drive(12'h101, 7'h11); step();
    bus.trace_req = 1'b0;
    repeat (200) step();
    drive(12'h202, 7'h22); step();
    drive(12'hF00, 7'h33); step();
    bus.trace_req   = 1'b0;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    repeat (2200) step();
    @(negedge clk);
    chk("busy_after_flush", 32'(bus.busy), 32'd0);
    chk("drain_sweep2", 32'(exp_q.size()), 32'd0);

    // Request in the FLUSH cycle and another in the following IDLE cycle.
    bus.clear_start = 1'b1;
    push_sweep(2400);
    exp_q.push_back(ent(12'h10A, 7'h0A, 1'b1, 1'b0));
    exp_q.push_back(ent(12'hE81, 7'h1B, 1'b1, 1'b0));
    step();
    bus.clear_start = 1'b0;
    repeat (2399) step();
    drive(12'h10A, 7'h0A); step();
    drive(12'hE81, 7'h1B); step();
    bus.trace_req = 1'b0;
    repeat (3) step();
    chk("drain_sweep3", 32'(exp_q.size()), 32'd0);

    // Reset after 1000 sweep writes with a held request: no flush, no resume.
    bus.clear_start = 1'b1;
    push_sweep(1000);
    step();
    bus.clear_start = 1'b0;
    repeat (300) step();
    drive(12'h101, 7'h11); step();
    bus.trace_req = 1'b0;
`ifdef TILE_CLR_VBLANK_EN
    bus.video_on = 1'b1;
    repeat (5) step();
    bus.video_on = 1'b0;
`endif
    repeat (698) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("busy_after_reset", 32'(bus.busy), 32'd0);
    chk("drain_reset", 32'(exp_q.size()), 32'd0);

    // Direct trace write works right after the aborted sweep.
    drive(12'h285, 7'h41);
    exp_q.push_back(ent(12'h285, 7'h41, 1'b1, 1'b0));
    step();
    bus.trace_req = 1'b0;
    step(); step();
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_wr_sched.md
# tile_wr_sched

Write-port scheduler for the 80x30 tile RAM behind the Etch A Sketch trace display. It arbitrates the single write port between cursor trace writes and a full-screen clear sweep (the "shake to erase" action), which writes a blank code to every visible tile. Trace writes that arrive during a sweep are held and written once the sweep ends, so the latest cursor mark survives. It sits between the cursor/trace logic and port A of `dual_port_ram`; the read/display path is untouched.

## Interface
- `MAX_X`, 80, visible tile columns (640/8)
- `MAX_Y`, 30, visible tile rows (480/16)
- `BLANK_CHAR`, 7'h00, code written by the clear sweep
- `clk_100MHz`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `trace_req`  in  1  trace write request, sampled every cycle while high
- `trace_addr`  in  12  {row[4:0], col[6:0]} of the trace write
- `trace_din`  in  7  code for the trace write
- `clear_start`  in  1  single-cycle pulse that starts a clear sweep
- `video_on`  in  1  active-video flag from the VGA timing; used only under the configuration macro
- `we`  out  1  tile RAM write enable (registered)
- `addr_w`  out  12  tile RAM write address (registered)
- `din`  out  7  tile RAM write data (registered)
- `trace_ack`  out  1  pulses with `we` for every trace write actually issued
- `busy`  out  1  high in CLEAR and FLUSH
- `clear_done`  out  1  one-cycle pulse on the last sweep write

## Operation
- States: IDLE, CLEAR, FLUSH.
- IDLE:
  - `trace_req` with an in-range address (col < MAX_X, row < MAX_Y) issues a write of `trace_addr`/`trace_din` with `trace_ack` = 1.
  - Out-of-range requests are dropped: no `we`, no ack.
- IDLE + `clear_start`: go to CLEAR with col = 0, row = 0 and `hold_valid` cleared.
  - A `trace_req` in the same cycle is captured into the hold register; it is not written directly.
- CLEAR:
  - Each enabled cycle writes `BLANK_CHAR` at {row, col}.
  - col increments; at MAX_X-1 col wraps to 0 and row increments.
  - Columns 80..127 are never addressed.
  - The write at {MAX_Y-1, MAX_X-1} asserts `clear_done` and moves to FLUSH.
  - Sweep length is MAX_X*MAX_Y = 2400 writes.
- CLEAR, trace handling:
  - In-range `trace_req` overwrites the hold register and sets `hold_valid` (last request wins).
  - Out-of-range requests are dropped.
  - `clear_start` is ignored.
- FLUSH (exactly one cycle):
  - If `hold_valid`, write the held address/data with `trace_ack` = 1 and clear `hold_valid`.
  - Always return to IDLE.
  - A `trace_req` in FLUSH is captured into the hold register and written on the next cycle in IDLE. If a second request arrives that IDLE cycle, the held one is written first and the new one is captured; the hold register drains before any direct write.
- At most one RAM write per cycle. Clear writes have priority over trace writes at all times.

## Timing
- All outputs are registered. A write decided in cycle n appears on `we`/`addr_w`/`din` in cycle n+1.
- IDLE trace latency: `trace_req` sampled at edge k produces `we` = 1 and `trace_ack` = 1 during cycle k+1.
- Sweep without throttling:
  - `clear_start` at edge k: first blank write (addr 12'h000) in cycle k+1, last write (addr 12'hECF) in cycle k+2400 together with `clear_done`.
  - Held trace write in cycle k+2401.
  - `busy` is high from cycle k+1 through k+2401.
- `reset_n` = 0 at an edge, including mid-sweep, forces IDLE and clears `hold_valid`, col and row.
- Reset value of every output is 0: `we`, `addr_w`, `din`, `trace_ack`, `busy`, `clear_done`.
- A sweep interrupted by reset does not resume.

## Configuration
- `TILE_CLR_VBLANK_EN` defined: CLEAR advances only in cycles where `video_on` = 0. When `video_on` = 1, no clear write is issued, col/row hold, and `busy` stays 1. Sweep length in cycles then depends on blanking.
- Not defined: `video_on` is ignored and the sweep runs one write per cycle.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles with `trace_req` = 1 -> all outputs 0; first ack one cycle after release.
- Trace write: `trace_req` with addr 12'h285 (row 5, col 5) and din 7'h41 in IDLE -> next cycle `we` = 1, `addr_w` = 12'h285, `din` = 7'h41, `trace_ack` = 1.
- Range check: `trace_addr` = 12'h050 (col 80) or 12'hF00 (row 30) -> no `we`, no ack.
- Full sweep: `clear_start` pulse ->
  - exactly 2400 writes of 7'h00, from 12'h000 to 12'hECF;
  - none with col >= 80;
  - `clear_done` once, on the last write;
  - `busy` high for 2401 cycles.
- Trace during sweep: requests to 12'h101/7'h11 then 12'h202/7'h22 mid-sweep -> no `trace_ack` during CLEAR; one FLUSH write of 12'h202/7'h22 right after `clear_done`.
- Reset mid-sweep: deassert `reset_n` after 1000 sweep writes with `hold_valid` set -> IDLE, no flush write, `busy` = 0. With `TILE_CLR_VBLANK_EN`, `video_on` = 1 stalls the sweep address.
